// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters / RAM and the ram_arbiter.
interface ram_arbiter_if;
  localparam int unsigned DW = 8;

  // requester side
  logic          req0;
  logic          we0;
  logic [DW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1;
  logic          we1;
  logic [DW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;

  // RAM side
  logic [DW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;

  // Arbiter view
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
    output ram_addr, ram_wdata, ram_we, ram_re
  );

  // Environment view: both requesters plus the RAM
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin RAM arbiter with bounded bursts and direct hand-over.
module ram_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic [CW-1:0] cnt_sat;
  logic [DW-1:0] ram_addr_c;
  logic [DW-1:0] ram_wdata_c;
  logic          ram_we_c;
  logic          ram_re_c;

  // Burst counter value after one more access, saturating at MAX_BURST
  always_comb begin
    cnt_sat = cnt_q;
    if (cnt_q < MAX_C) begin
      cnt_sat = cnt_q + CW'(1);
    end
  end

  // Next-state, pointer, counter and RAM-side outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // tie goes to the port that did not own the RAM last
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = OWN0;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (bus.req1) begin
          state_d = OWN1;
          cnt_d   = '0;
          last_d  = 1'b1;
        end
      end

      OWN0: begin
        ram_addr_c  = bus.addr0;
        ram_wdata_c = bus.wdata0;
        ram_we_c    = bus.req0 & bus.we0;
        ram_re_c    = bus.req0 & ~bus.we0;
        if (!bus.req0) begin
          state_d = IDLE;
        end else begin
          rvalid0_d = ~bus.we0;
          if ((cnt_sat == MAX_C) && bus.req1) begin
            state_d = OWN1;
            cnt_d   = '0;
            last_d  = 1'b1;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      OWN1: begin
        ram_addr_c  = bus.addr1;
        ram_wdata_c = bus.wdata1;
        ram_we_c    = bus.req1 & bus.we1;
        ram_re_c    = bus.req1 & ~bus.we1;
        if (!bus.req1) begin
          state_d = IDLE;
        end else begin
          rvalid1_d = ~bus.we1;
          if ((cnt_sat == MAX_C) && bus.req0) begin
            state_d = OWN0;
            cnt_d   = '0;
            last_d  = 1'b0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, burst counter, last-owner pointer and read-valid registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Output drive: grants decode the state register, RAM side follows the owner
  assign bus.gnt0      = (state_q == OWN0);
  assign bus.gnt1      = (state_q == OWN1);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = bus.ram_rdata;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_re    = ram_re_c;

endmodule
